entropy_requester: RTL
======================

Name: entropy_requester

Overview:
- Host-side initiator for the TRNG entropy request interface: drives req/req_ss toward the entropy buffer and consumes the returned 8-bit vector/vector_valid responses.
- Issues WORD_BYTES byte requests and packs the returned bytes into one word.
- Presents the word downstream with a valid/ready handshake.
- Sits between the TRNG core and any consumer, e.g. a bus register or a self-test harness.

Parameters:
WORD_BYTES, 4, number of entropy bytes packed per word (1..8)
TIMEOUT, 1023, maximum cycles to wait for vector_valid per byte request before aborting (1..65535)

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  synchronous, active-high reset
start  input  1  pulse/level; request one word (sampled in IDLE only)
single_shot  input  1  mode for this word: 1 = single-shot request pulses, 0 = level request; latched on start acceptance
req  output  1  entropy request toward buffer (registered)
req_ss  output  1  single-shot mode indicator toward buffer (registered; equals latched single_shot)
vector  input  8  entropy byte from buffer
vector_valid  input  1  vector holds a valid byte this cycle
word  output  8*WORD_BYTES  packed entropy word; byte k in bits [8k+7:8k]; first received byte = byte 0
word_valid  output  1  word available
word_ready  input  1  downstream accepts word
busy  output  1  high in any state other than IDLE
timeout_err  output  1  sticky: last word aborted by timeout
byte_cnt  output  3  bytes captured so far for the current word

Behaviour:
- Reset (rst=1 at posedge) outputs: req=0, req_ss=0, word=0, word_valid=0, busy=0, timeout_err=0, byte_cnt=0, timer=0, state=IDLE. Reset mid-transaction abandons it immediately: no word is presented and the error is not flagged.
- States: IDLE, REQ, WAIT, GAP, DONE.
- IDLE: start=1 moves to REQ next cycle.
  - On that edge: latch single_shot into req_ss; clear timeout_err; byte_cnt=0; timer=0.
- REQ: req=1 for exactly this one cycle; next state WAIT (unless capture).
- WAIT:
  - single_shot=1: req=0.
  - single_shot=0: req held at 1 until capture.
- Timer:
  - Increments every cycle in REQ and WAIT.
  - Timer starts at 0 on REQ entry.
- Capture: vector_valid=1 sampled in REQ or WAIT.
  - Store vector into byte slot byte_cnt; byte_cnt+1.
  - req=0 from the next cycle; go to GAP.
- GAP: exactly one cycle with req=0, guaranteeing a req falling edge between requests.
  - byte_cnt==WORD_BYTES moves to DONE; otherwise moves to REQ with timer=0.
- Request latency: first req high 1 cycle after start accepted.
  - Minimum per-byte period is 3 cycles (REQ with immediate valid, GAP, next REQ).
- Timeout: timer reaches TIMEOUT in REQ/WAIT without vector_valid.
  - Set timeout_err=1, req=0, byte_cnt=0, word unchanged, go IDLE.
  - vector_valid in the same cycle as the timeout: capture wins, no error.
- vector_valid in IDLE, GAP or DONE is ignored; word and byte_cnt are unchanged.
- DONE:
  - word_valid=1; word stable until handshake.
  - word_valid & word_ready on posedge: word_valid=0 next cycle, go IDLE.
  - start in DONE is ignored (no queuing).
  - word_ready while word_valid=0 has no effect.
- busy = (state != IDLE).
- Widths: timer 16 bits; comparison against TIMEOUT is unsigned equality.

Test Plan:
- Reset, then start=1 with single_shot=1, WORD_BYTES=4; responder returns 0x11,0x22,0x33,0x44 one cycle after each req pulse -> req is a 1-cycle pulse per byte, req_ss=1, word=0x44332211, word_valid=1; word_ready=1 -> word_valid=0 and busy=0 next cycle.
- Level mode (single_shot=0), responder delays vector_valid 5 cycles -> req high for 6 consecutive cycles per byte, low for exactly 1 GAP cycle, req_ss=0.
- TIMEOUT=8, responder never answers -> req drops after 8 cycles, timeout_err=1, busy=0, word_valid=0, byte_cnt=0. Next start clears timeout_err.
- vector_valid coincident with the timeout cycle (TIMEOUT=8, valid on cycle 8) -> byte captured, timeout_err stays 0.
- Spurious vector_valid=1 with vector=0xAA in IDLE and GAP -> no change to word or byte_cnt. start held high in DONE with word_ready=0 -> word stays valid and no new req issued.
- rst=1 asserted after 2 of 4 bytes -> next cycle req=0, byte_cnt=0, word=0, busy=0, timeout_err=0.

Source files
------------

// File: rtl/entropy_requester.sv
// ---------------------------------------------------------------------------
// entropy_requester
//
// Host-side initiator for the TRNG entropy request interface. For each word
// it issues WORD_BYTES byte requests toward the entropy buffer, packs the
// returned bytes (first byte received -> byte 0) and offers the packed word
// downstream.
//
// Ports:
//   clk, rst      : system clock, synchronous active-high reset
//   start         : request one word (only looked at in IDLE)
//   single_shot   : 1 = single-cycle req pulses, 0 = req held until answered;
//                   latched when start is accepted
//   req, req_ss   : registered request / single-shot indicator to the buffer
//   vector        : entropy byte from the buffer
//   vector_valid  : vector holds a valid byte this cycle
//   word          : packed entropy word, byte k in bits [8k+7:8k]
//   word_valid    : word available downstream
//   word_ready    : downstream accepts word
//   busy          : FSM is not in IDLE
//   timeout_err   : sticky, last word aborted by timeout (cleared on start)
//   byte_cnt      : bytes captured so far for the current word
//   state_dbg     : current FSM state (IDLE=0, REQ=1, WAIT=2, GAP=3, DONE=4)
//
// Downstream handshake: word_valid rises when the word is complete and stays
// high with word stable until a posedge where word_valid && word_ready; the
// word is transferred on that edge and word_valid is low the next cycle.
// word_ready while word_valid is low has no effect.
// ---------------------------------------------------------------------------
module entropy_requester #(
  parameter int WORD_BYTES = 4,
  parameter int TIMEOUT    = 1023
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    single_shot,
  output logic                    req,
  output logic                    req_ss,
  input  logic [7:0]              vector,
  input  logic                    vector_valid,
  output logic [8*WORD_BYTES-1:0] word,
  output logic                    word_valid,
  input  logic                    word_ready,
  output logic                    busy,
  output logic                    timeout_err,
  output logic [2:0]              byte_cnt,
  output logic [2:0]              state_dbg
);

  localparam int WW = 8 * WORD_BYTES;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic            req_q, req_d;
  logic            req_ss_q, req_ss_d;
  logic [WW-1:0]   word_q, word_d;
  logic            word_valid_q, word_valid_d;
  logic            timeout_err_q, timeout_err_d;
  // One bit wider than the byte_cnt port so a full 8-byte word is still
  // distinguishable from zero bytes when deciding GAP -> DONE.
  logic [3:0]      cnt_q, cnt_d;
  logic [15:0]     timer_q, timer_d;
  logic [15:0]     timer_inc;

  assign timer_inc = timer_q + 16'd1;

  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    req_ss_d      = req_ss_q;
    word_d        = word_q;
    word_valid_d  = word_valid_q;
    timeout_err_d = timeout_err_q;
    cnt_d         = cnt_q;
    timer_d       = timer_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d       = S_REQ;
          req_d         = 1'b1;
          req_ss_d      = single_shot;
          timeout_err_d = 1'b0;
          cnt_d         = 4'd0;
          timer_d       = 16'd0;
        end
      end

      S_REQ, S_WAIT: begin
        timer_d = timer_inc;
        if (vector_valid) begin
          // Capture has priority over a timeout in the same cycle.
          for (int k = 0; k < WORD_BYTES; k++) begin
            if (cnt_q == 4'(k)) begin
              word_d[8*k +: 8] = vector;
            end
          end
          cnt_d   = cnt_q + 4'd1;
          req_d   = 1'b0;
          state_d = S_GAP;
        end else if (timer_inc == 16'(TIMEOUT)) begin
          timeout_err_d = 1'b1;
          req_d         = 1'b0;
          cnt_d         = 4'd0;
          state_d       = S_IDLE;
        end else begin
          // Single-shot drops req after the REQ cycle; level mode holds it.
          req_d   = ~req_ss_q;
          state_d = S_WAIT;
        end
      end

      S_GAP: begin
        // req is low for this cycle, guaranteeing a falling edge between
        // consecutive byte requests.
        if (cnt_q == 4'(WORD_BYTES)) begin
          state_d      = S_DONE;
          word_valid_d = 1'b1;
        end else begin
          state_d = S_REQ;
          req_d   = 1'b1;
          timer_d = 16'd0;
        end
      end

      S_DONE: begin
        if (word_ready) begin
          word_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end

      default: begin
        state_d      = S_IDLE;
        req_d        = 1'b0;
        word_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      req_q         <= 1'b0;
      req_ss_q      <= 1'b0;
      word_q        <= '0;
      word_valid_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      cnt_q         <= 4'd0;
      timer_q       <= 16'd0;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      req_ss_q      <= req_ss_d;
      word_q        <= word_d;
      word_valid_q  <= word_valid_d;
      timeout_err_q <= timeout_err_d;
      cnt_q         <= cnt_d;
      timer_q       <= timer_d;
    end
  end

  assign req         = req_q;
  assign req_ss      = req_ss_q;
  assign word        = word_q;
  assign word_valid  = word_valid_q;
  assign timeout_err = timeout_err_q;
  assign byte_cnt    = cnt_q[2:0];
  assign busy        = (state_q != S_IDLE);
  assign state_dbg   = state_q;

endmodule
